instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's RV32I instruction decoder: packs decoded fields (format, opcode, funct3/funct7, register indices, immediate) into 32-bit RV32I instruction words.
- Elastic valid/ready pipeline with a 2-stage datapath and a running write address.
- Sits between the test/boot program generator and the instruction-memory write port, so generated programs stream straight into imem.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word after reset or restart.
- ADDR_W, 32, width of out_addr.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- restart  in  1  synchronous; reloads the address counter to BASE_ADDR and flushes the pipeline.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder accepts the tuple this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12] (R/I/S/B).
- in_funct7  in  7  instruction[31:25] (R only).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  sign-extended immediate value (B/J as byte offsets; U as the full value with low 12 bits expected zero).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for out_instr.
- out_err  out  1  encoding error flag for this word (see Optional Feature).

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, both stage-valid bits=0, address counter=BASE_ADDR. in_ready is 1 in the cycle after reset deasserts.
- Pipeline
  - S1 registers the accepted tuple.
  - S2 computes and registers the word, address and error flag. Stage-2 registers drive the out_* ports directly.
- Latency: a tuple accepted in cycle N appears on out_* in cycle N+2 when there is no backpressure.
- Throughput: 1 word/cycle.
- Handshake
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from stage valids and out_ready).
  - A transfer occurs when valid&&ready.
  - out_instr, out_addr and out_err are held stable while out_valid && !out_ready.
- Encoding
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. Shift-immediates carry funct7 in imm[11:5].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Illegal fmt: word = 32'h0000_0000; out_err=1 regardless of macro.
  - Fields unused by a format are ignored.
- Address counter
  - Assigned at S2 load: the word receives the counter value, and the counter += 4 at that moment.
  - Wraps modulo 2^ADDR_W without error.
- restart: same cycle as a handshake, restart wins. The tuple is dropped, both stages are invalidated, and the counter is set to BASE_ADDR. rst has priority over restart.
- Reset mid-stream: all in-flight words are discarded, and no out_valid appears in the cycle after rst.

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- Defined: S2 sets out_err=1 on any of:
  - I/S imm outside [-2048, 2047];
  - B imm outside [-4096, 4094] or imm[0]≠0;
  - J imm outside [-2^20, 2^20-2] or imm[0]≠0;
  - U imm[11:0]≠0.
  The word is still emitted with truncated fields.
- Undefined: out_err is set only for illegal fmt; no range logic is synthesized.

Test Plan:
- I, op 0x13, f3 0, rd1, rs1 0, imm 5 → out_instr 0x00500093 at out_addr BASE_ADDR, two cycles after accept, out_err=0.
- Back-to-back stream:
  - R add x3,x1,x2 (op 0x33) → 0x002081B3;
  - S sw x2,8(x1) (op 0x23, f3 2) → 0x0020A423;
  - B beq x0,x0,-4 (op 0x63) → 0xFE000EE3;
  - expect addresses +0, +4, +8 on consecutive cycles.
- J jal x1,2048 (op 0x6F) → 0x001000EF; U lui x5,0x12345000 (op 0x37) → 0x123452B7.
- Hold out_ready=0 for 5 cycles with in_valid=1: in_ready falls after 2 accepts, out_* stays stable, and no word is lost or duplicated on release.
- I with imm 2048:
  - with the macro, out_err=1 and word 0x80000093 for rd1;
  - without the macro, out_err=0;
  - fmt=7 → word 0, out_err=1 in both builds.
- Assert restart while 2 words are in flight → out_valid=0 next cycle, and the next accepted word gets out_addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-tuple input stream and encoded-word output stream of instr_encoder.
// The master drives fields and out_ready; the slave is the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [6:0]        in_opcode;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;

   modport master (
      output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: 2-stage elastic pipeline with running write address.
// Define INSTR_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their format.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            restart,
   instr_encoder_if.slave  bus
);
   logic              s1_valid;
   logic              s2_valid;
   logic              s1_adv;
   logic              s2_adv;
   logic [2:0]        s1_fmt;
   logic [6:0]        s1_opcode;
   logic [2:0]        s1_funct3;
   logic [6:0]        s1_funct7;
   logic [4:0]        s1_rd;
   logic [4:0]        s1_rs1;
   logic [4:0]        s1_rs2;
   logic [31:0]       s1_imm;
   logic [ADDR_W-1:0] addr_cnt;
   logic [31:0]       word;
   logic              illegal;
   logic              range_err;

   assign s2_adv        = !s2_valid || bus.out_ready;
   assign s1_adv        = !s1_valid || s2_adv;
   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_fmt    <= bus.in_fmt;
            s1_opcode <= bus.in_opcode;
            s1_funct3 <= bus.in_funct3;
            s1_funct7 <= bus.in_funct7;
            s1_rd     <= bus.in_rd;
            s1_rs1    <= bus.in_rs1;
            s1_rs2    <= bus.in_rs2;
            s1_imm    <= bus.in_imm;
         end
      end
   end

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (s1_fmt)
         3'd0: word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
         3'd1: word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
         3'd2: word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
         3'd3: word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                       s1_imm[4:1], s1_imm[11], s1_opcode};
         3'd4: word = {s1_imm[31:12], s1_rd, s1_opcode};
         3'd5: word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
         default: illegal = 1'b1;
      endcase
   end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   logic signed [31:0] simm;
   assign simm = $signed(s1_imm);

   // Immediates are checked as signed values against what each format can represent.
   always_comb begin
      range_err = 1'b0;
      case (s1_fmt)
         3'd1, 3'd2: range_err = (simm < -32'sd2048) || (simm > 32'sd2047);
         3'd3:       range_err = (simm < -32'sd4096) || (simm > 32'sd4094) || s1_imm[0];
         3'd4:       range_err = (s1_imm[11:0] != 12'd0);
         3'd5:       range_err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || s1_imm[0];
         default:    range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

   // Address is bound to a word when it enters S2, so stalls never skip or reuse addresses.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid      <= 1'b0;
         bus.out_instr <= '0;
         bus.out_addr  <= BASE_ADDR;
         bus.out_err   <= 1'b0;
         addr_cnt      <= BASE_ADDR;
      end else if (restart) begin
         s2_valid <= 1'b0;
         addr_cnt <= BASE_ADDR;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_instr <= word;
            bus.out_addr  <= addr_cnt;
            bus.out_err   <= illegal || range_err;
            addr_cnt      <= addr_cnt + ADDR_W'(4);
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder with a scoreboard-checked output stream.
module tb_instr_encoder;
   localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic restart = 1'b0;
   int   total_cnt = 0;
   int   pass_cnt = 0;
   vec_t tbl [13];
   exp_t exp_q [$];
   exp_t mon_e;
   logic [31:0] exp_addr = BASE;
   int   accepts;
   int   k;

   instr_encoder_if #(.ADDR_W(32)) bus ();

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      else
         pass_cnt++;
   endtask

   task automatic driveFields(input vec_t v);
      bus.in_fmt    = v.fmt;
      bus.in_opcode = v.opcode;
      bus.in_funct3 = v.funct3;
      bus.in_funct7 = v.funct7;
      bus.in_rd     = v.rd;
      bus.in_rs1    = v.rs1;
      bus.in_rs2    = v.rs2;
      bus.in_imm    = v.imm;
   endtask

   task automatic pushExpected(input vec_t v);
      exp_q.push_back('{v.instr, exp_addr, v.err});
      exp_addr = exp_addr + 32'd4;
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the tuple.
   task automatic applyStimulus(input int idx);
      bit done = 0;
      driveFields(tbl[idx]);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            pushExpected(tbl[idx]);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         total_cnt++;
         $display("[TB] FAIL accept_timeout vec %0d: in_ready stayed 0, expected 1 within 20 cycles", idx);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("[TB] FAIL unexpected_word: got 0x%08h @0x%08h, expected no word", bus.out_instr, bus.out_addr);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("out_instr", bus.out_instr, mon_e.instr);
            checkOutput("out_addr", bus.out_addr, mon_e.addr);
            checkOutput("out_err", {31'b0, bus.out_err}, {31'b0, mon_e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b0};
      tbl[1]  = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF,  32'h002081B3, 1'b0};
      tbl[2]  = '{3'd2, 7'h23, 3'd2, 7'h7F, 5'd9, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0};
      tbl[3]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,  32'hFE000EE3, 1'b0};
      tbl[4]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800,  32'h001000EF, 1'b0};
      tbl[5]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0};
      tbl[6]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h80000093, RC};
      tbl[7]  = '{3'd7, 7'h33, 3'd5, 7'h20, 5'd5, 5'd6, 5'd7, 32'h12345678,  32'h00000000, 1'b1};
      tbl[8]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'hDEADBEEF,  32'h407302B3, 1'b0};
      tbl[9]  = '{3'd6, 7'h13, 3'd1, 7'h01, 5'd1, 5'd1, 5'd1, 32'd1,         32'h00000000, 1'b1};
      tbl[10] = '{3'd1, 7'h13, 3'd5, 7'h00, 5'd1, 5'd2, 5'd0, 32'h00000403,  32'h40315093, 1'b0};
      tbl[11] = '{3'd3, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00209463, 1'b0};
      tbl[12] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00001001,  32'h000010B7, RC};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      driveFields(tbl[0]);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset_out_instr", bus.out_instr, 32'd0);
      checkOutput("reset_out_addr", bus.out_addr, BASE);
      checkOutput("reset_out_err", {31'b0, bus.out_err}, 32'd0);
      checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      $display("[TB] latency: single addi");
      applyStimulus(0);
      @(negedge clk);
      checkOutput("latency_n1_out_valid", {31'b0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("latency_n2_out_valid", {31'b0, bus.out_valid}, 32'd1);
      waitCycles(2);

      $display("[TB] back-to-back table stream");
      for (int i = 0; i < 13; i++) applyStimulus(i);
      waitCycles(5);
      checkOutput("stream_drained", exp_q.size(), 32'd0);

      $display("[TB] backpressure hold");
      bus.out_ready = 1'b0;
      accepts = 0;
      k = 0;
      for (int c = 0; c < 5; c++) begin
         driveFields(tbl[1 + (k % 2)]);
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) begin
            pushExpected(tbl[1 + (k % 2)]);
            accepts++;
            k++;
         end
         if (c >= 2 && exp_q.size() > 0) begin
            checkOutput("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("hold_out_instr", bus.out_instr, exp_q[0].instr);
            checkOutput("hold_out_addr", bus.out_addr, exp_q[0].addr);
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      checkOutput("hold_accepts", accepts, 32'd2);
      bus.out_ready = 1'b1;
      waitCycles(5);
      checkOutput("hold_drained", exp_q.size(), 32'd0);

      // Restart with two words in flight and a competing handshake in the same cycle.
      $display("[TB] restart with words in flight");
      bus.out_ready = 1'b0;
      applyStimulus(1);
      applyStimulus(2);
      restart = 1'b1;
      driveFields(tbl[5]);
      bus.in_valid = 1'b1;
      exp_q.delete();
      exp_addr = BASE;
      @(posedge clk);
      #1;
      restart = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("restart_out_valid", {31'b0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      applyStimulus(4);
      waitCycles(5);
      checkOutput("restart_drained", exp_q.size(), 32'd0);

      $display("[TB] reset mid-stream");
      bus.out_ready = 1'b0;
      applyStimulus(8);
      applyStimulus(10);
      rst = 1'b1;
      exp_q.delete();
      exp_addr = BASE;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("midreset_out_addr", bus.out_addr, BASE);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      applyStimulus(3);
      applyStimulus(11);
      waitCycles(5);
      checkOutput("final_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
